unidade_controle: RTL and testbench
===================================

Name: unidade_controle

Overview:
- Multi-cycle control FSM that sequences the RV64 datapath: PC, ULAPC, instruction memory/register, BancoRegistradores, ULA, MemoryData and the immediate generators.
- Takes the latched instruction fields and the ULA zero flag as inputs.
- Drives every write enable and mux select one phase at a time.
- Replaces the ad-hoc delay-based sequencing in the testbench with a clocked, reset-clean controller.

Parameters:
- XLEN, 64, datapath width; sets the width of `instret` only.
- BRANCH_NE_EN_DEFAULT, 1, 1 = decode `bne` (funct3 001) in addition to `beq` (000); 0 = `bne` treated as illegal.

Ports:
- `clk`  in  1  system clock, posedge
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  7  `instr[6:0]` from instruction register
- `funct3`  in  3  `instr[14:12]`
- `funct7`  in  7  `instr[31:25]`
- `zero`  in  1  ULA result == 0
- `ir_we`  out  1  load instruction register
- `pc_we`  out  1  load PC
- `pc_sel`  out  2  0=PC+4, 1=PC+imm, 2=ULA result with bit0 cleared
- `we_reg`  out  1  register file write enable
- `we_mem`  out  1  data memory write enable
- `alu_sub`  out  1  ULA subtract
- `alu_imm`  out  1  ULA B operand = immediate
- `imm_sel`  out  3  0=I, 1=S, 2=B, 3=J, 4=U
- `wb_sel`  out  2  0=ULA, 1=memory, 2=PC+4, 3=PC+imm_U
- `estado`  out  3  current state
- `illegal`  out  1  sticky illegal-instruction flag
- `instret`  out  XLEN  retired instruction count

Behaviour:
- `rst_n` low, asynchronous: state=IDLE(0), `illegal`=0, `instret`=0, all enables 0, all selects 0. Reset asserted mid-instruction aborts it; no write enable may be high in the reset cycle.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Outputs are Moore: decoded from the state plus the opcode/funct fields, which are stable after FETCH.
- Transitions:
  - IDLE: always → FETCH.
  - FETCH: `ir_we`=1 → DECODE.
  - DECODE: `imm_sel` valid. `jal` → WB; illegal opcode → HALT (or FETCH, see Optional Feature); otherwise → EXEC.
  - EXEC: ALU controls valid.
    - `lw`/`sw`: `alu_imm`=1, `alu_sub`=0, `imm_sel`=I (lw) or S (sw) → MEM.
    - `add_sub`: `alu_imm`=0, `alu_sub`=`funct7[5]` → WB.
    - `addi`, `jalr`: `alu_imm`=1 → WB.
    - `auipc`: → WB.
    - branch: `alu_sub`=1, `pc_we`=1, `pc_sel`=1 if taken else 0 → FETCH. Taken = `beq`&`zero` or `bne`&~`zero`.
  - MEM:
    - `sw`: `we_mem`=1, `pc_we`=1, `pc_sel`=0 → FETCH.
    - `lw`: → WB; memory read completes this cycle.
  - WB: `we_reg`=1 and `pc_we`=1 in the same cycle.
    - `lw`: `wb_sel`=1.
    - `add_sub`, `addi`: `wb_sel`=0.
    - `jal`: `wb_sel`=2, `pc_sel`=1, `imm_sel`=J.
    - `jalr`: `wb_sel`=2, `pc_sel`=2.
    - `auipc`: `wb_sel`=3, `imm_sel`=U.
    - Then → FETCH.
  - HALT: all enables 0, stays until reset.
- Cycles per instruction, FETCH to the next FETCH: `lw` 5, `sw` 4, `add`/`sub`/`addi`/`jalr`/`auipc` 4, branch 3, `jal` 3.
- Legality rules:
  - `add_sub` requires funct3=000 and funct7 ∈ {0000000, 0100000}.
  - `addi`, `lw`, `sw`, `jalr` require funct3 per RV64 (lw=010, sw=010, addi=000, jalr=000).
  - Anything else is illegal.
- `pc_we` is high exactly one cycle per retired instruction. `instret` increments in that same cycle and wraps at 2^XLEN−1 → 0.
- `we_reg` and `we_mem` are never high together. rd=x0 is still written; the register file discards it.

Optional Feature:
- Macro: `UNIDADE_CONTROLE_TRAP_EN`.
- Defined: an illegal instruction at DECODE sets `illegal`=1 and moves to HALT; `pc_we` is not asserted and `instret` does not increment.
- Undefined: an illegal instruction is treated as a NOP. DECODE → FETCH with `pc_we`=1, `pc_sel`=0 and `instret`++. `illegal` pulses high for that one cycle only; it is not sticky, and HALT is unreachable.

Test Plan:
- Reset then release, `opcode`=0x33 (add): `estado` 0→1→2→3→5→1. `we_reg`=1 and `pc_we`=1 only in state 5; `alu_sub`=0; `instret`=1.
- `opcode`=0x03 (lw), funct3=010: `we_reg`=1 and `wb_sel`=1 in cycle 5. `we_mem` stays 0 throughout. `instret` increments once.
- `opcode`=0x23 (sw): `we_mem`=1 with `imm_sel`=1 in state 4, concurrent with `pc_we`=1. `we_reg` stays 0. 4 cycles total.
- `beq` with `zero`=1, then with `zero`=0: EXEC gives `pc_sel`=1 then `pc_sel`=0. Each takes 3 cycles; `we_reg` never asserts.
- `jal` then `jalr`:
  - `jal`: 3 cycles, WB with `wb_sel`=2, `pc_sel`=1.
  - `jalr`: 4 cycles, WB with `pc_sel`=2.
- `opcode`=0x7F: with `UNIDADE_CONTROLE_TRAP_EN` → `estado`=6, `illegal`=1, `instret` unchanged. Without it → one-cycle `illegal` pulse, `instret`+1. Assert `rst_n` low mid-EXEC → all outputs 0 immediately.

Source files
------------

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM sequencing the RV64 datapath (PC, IR, register file, ULA, data memory).
// Optional: define UNIDADE_CONTROLE_TRAP_EN to trap illegal instructions into HALT instead of skipping them.
module unidade_controle #(
  parameter int XLEN                 = 64,
  parameter bit BRANCH_NE_EN_DEFAULT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            zero,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            we_reg,
  output logic            we_mem,
  output logic            alu_sub,
  output logic            alu_imm,
  output logic [2:0]      imm_sel,
  output logic [1:0]      wb_sel,
  output logic [2:0]      estado,
  output logic            illegal,
  output logic [XLEN-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LW    = 7'h03;
  localparam logic [6:0] OP_SW    = 7'h23;
  localparam logic [6:0] OP_RR    = 7'h33;
  localparam logic [6:0] OP_ADDI  = 7'h13;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_BR    = 7'h63;

  state_t          state_q, state_d;
  logic [XLEN-1:0] instret_q;

  logic is_lw, is_sw, is_rr, is_addi, is_jalr, is_jal, is_auipc, is_br;
  logic legal, taken, alu_sub_dec, alu_imm_dec, ill_now;
  logic [2:0] imm_dec;

  always_comb begin
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_rr    = (opcode == OP_RR);
    is_addi  = (opcode == OP_ADDI);
    is_jalr  = (opcode == OP_JALR);
    is_jal   = (opcode == OP_JAL);
    is_auipc = (opcode == OP_AUIPC);
    is_br    = (opcode == OP_BR);

    legal = (is_rr && funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000))
         || (is_lw   && funct3 == 3'b010)
         || (is_sw   && funct3 == 3'b010)
         || (is_addi && funct3 == 3'b000)
         || (is_jalr && funct3 == 3'b000)
         || is_jal || is_auipc
         || (is_br && (funct3 == 3'b000 || (BRANCH_NE_EN_DEFAULT && funct3 == 3'b001)));

    // Only beq/bne ever reach EXEC, so funct3 bit 0 alone picks the polarity.
    taken = funct3[0] ? ~zero : zero;

    alu_sub_dec = is_br | (is_rr & funct7[5]);
    alu_imm_dec = is_lw | is_sw | is_addi | is_jalr;

    imm_dec = 3'd0;
    if (is_sw)         imm_dec = 3'd1;
    else if (is_br)    imm_dec = 3'd2;
    else if (is_jal)   imm_dec = 3'd3;
    else if (is_auipc) imm_dec = 3'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_we) instret_q <= instret_q + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 2'd0;
    we_reg  = 1'b0;
    we_mem  = 1'b0;
    alu_sub = 1'b0;
    alu_imm = 1'b0;
    imm_sel = 3'd0;
    wb_sel  = 2'd0;
    ill_now = 1'b0;

    // ALU controls stay applied through MEM/WB so the address / jalr target remains stable.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_sub = alu_sub_dec;
      alu_imm = alu_imm_dec;
    end
    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)
      imm_sel = imm_dec;

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        ir_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          ill_now = 1'b1;
`ifdef UNIDADE_CONTROLE_TRAP_EN
          state_d = S_HALT;
`else
          pc_we   = 1'b1;
          state_d = S_FETCH;
`endif
        end else if (is_jal) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_br) begin
          pc_we   = 1'b1;
          pc_sel  = taken ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          we_mem  = 1'b1;
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        we_reg  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        if (is_lw) begin
          wb_sel = 2'd1;
        end else if (is_jal) begin
          wb_sel = 2'd2;
          pc_sel = 2'd1;
        end else if (is_jalr) begin
          wb_sel = 2'd2;
          pc_sel = 2'd2;
        end else if (is_auipc) begin
          wb_sel = 2'd3;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UNIDADE_CONTROLE_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else if (ill_now) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = ill_now;
`endif

  assign estado  = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: per-cycle expected output vectors for each instruction class.
module tb_unidade_controle;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        zero;
  logic        ir_we, pc_we, we_reg, we_mem, alu_sub, alu_imm, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel, estado;
  logic [63:0] instret;

  unidade_controle #(.XLEN(64), .BRANCH_NE_EN_DEFAULT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .we_reg(we_reg), .we_mem(we_mem),
    .alu_sub(alu_sub), .alu_imm(alu_imm), .imm_sel(imm_sel), .wb_sel(wb_sel),
    .estado(estado), .illegal(illegal), .instret(instret)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1);
  end

  // Observed outputs: {estado, ir_we, pc_we, pc_sel, we_reg, we_mem, alu_sub, alu_imm, imm_sel, wb_sel, illegal}
  logic [16:0] obs;
  assign obs = {estado, ir_we, pc_we, pc_sel, we_reg, we_mem, alu_sub, alu_imm, imm_sel, wb_sel, illegal};

  // Scoreboard
  logic [16:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_instret = 64'd0;

  function automatic logic [16:0] v(input logic [2:0] est, input logic irw, input logic pcw,
                                    input logic [1:0] pcs, input logic wr, input logic wm,
                                    input logic sub, input logic aimm, input logic [2:0] isel,
                                    input logic [1:0] wbs, input logic ill);
    return {est, irw, pcw, pcs, wr, wm, sub, aimm, isel, wbs, ill};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: entered at posedge+1 of a FETCH cycle; checks one queued vector per cycle.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input bit retires);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    zero   = z;
    check({tag, " instret"}, instret, exp_instret);
    for (int k = 0; exp_q.size() > 0; k++) begin
      check($sformatf("%s c%0d", tag, k), 64'(obs), 64'(exp_q.pop_front()));
      @(posedge clk);
      #1;
    end
    if (retires) exp_instret++;
  endtask

  logic [16:0] f_vec;

  initial begin
    f_vec  = v(3'd1, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0);
    rst_n  = 1'b0;
    opcode = 7'h33;
    funct3 = 3'd0;
    funct7 = 7'd0;
    zero   = 1'b0;

    @(posedge clk);
    #1;
    check("reset outputs", 64'(obs), 64'd0);
    check("reset instret", instret, 64'd0);
    rst_n = 1'b1;
    #1;
    check("idle after release", 64'(obs), 64'd0);
    @(posedge clk);
    #1;

    // add
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd5, 0, 1, 2'd0, 1, 0, 0, 0, 3'd0, 2'd0, 0));
    run_instr("add", 7'h33, 3'd0, 7'h00, 1'b0, 1);

    // sub
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 0, 2'd0, 0, 0, 1, 0, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd5, 0, 1, 2'd0, 1, 0, 1, 0, 3'd0, 2'd0, 0));
    run_instr("sub", 7'h33, 3'd0, 7'h20, 1'b0, 1);

    // lw
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 0, 2'd0, 0, 0, 0, 1, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd4, 0, 0, 2'd0, 0, 0, 0, 1, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd5, 0, 1, 2'd0, 1, 0, 0, 1, 3'd0, 2'd1, 0));
    run_instr("lw", 7'h03, 3'd2, 7'h00, 1'b0, 1);

    // sw
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd1, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 0, 2'd0, 0, 0, 0, 1, 3'd1, 2'd0, 0));
    exp_q.push_back(v(3'd4, 0, 1, 2'd0, 0, 1, 0, 1, 3'd1, 2'd0, 0));
    run_instr("sw", 7'h23, 3'd2, 7'h00, 1'b0, 1);

    // beq taken
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd2, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 1, 2'd1, 0, 0, 1, 0, 3'd2, 2'd0, 0));
    run_instr("beq_t", 7'h63, 3'd0, 7'h00, 1'b1, 1);

    // beq not taken
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd2, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 1, 2'd0, 0, 0, 1, 0, 3'd2, 2'd0, 0));
    run_instr("beq_nt", 7'h63, 3'd0, 7'h00, 1'b0, 1);

    // bne taken (zero=0) and not taken (zero=1)
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd2, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 1, 2'd1, 0, 0, 1, 0, 3'd2, 2'd0, 0));
    run_instr("bne_t", 7'h63, 3'd1, 7'h00, 1'b0, 1);
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd2, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 1, 2'd0, 0, 0, 1, 0, 3'd2, 2'd0, 0));
    run_instr("bne_nt", 7'h63, 3'd1, 7'h00, 1'b1, 1);

    // jal
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd3, 2'd0, 0));
    exp_q.push_back(v(3'd5, 0, 1, 2'd1, 1, 0, 0, 0, 3'd3, 2'd2, 0));
    run_instr("jal", 7'h6F, 3'd5, 7'h11, 1'b0, 1);

    // jalr
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 0, 2'd0, 0, 0, 0, 1, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd5, 0, 1, 2'd2, 1, 0, 0, 1, 3'd0, 2'd2, 0));
    run_instr("jalr", 7'h67, 3'd0, 7'h00, 1'b0, 1);

    // auipc
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd4, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 0, 2'd0, 0, 0, 0, 0, 3'd4, 2'd0, 0));
    exp_q.push_back(v(3'd5, 0, 1, 2'd0, 1, 0, 0, 0, 3'd4, 2'd3, 0));
    run_instr("auipc", 7'h17, 3'd0, 7'h00, 1'b0, 1);

    // addi
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd3, 0, 0, 2'd0, 0, 0, 0, 1, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd5, 0, 1, 2'd0, 1, 0, 0, 1, 3'd0, 2'd0, 0));
    run_instr("addi", 7'h13, 3'd0, 7'h00, 1'b0, 1);

`ifdef UNIDADE_CONTROLE_TRAP_EN
    // Illegal opcode traps into HALT and stays there.
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    exp_q.push_back(v(3'd6, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 1));
    exp_q.push_back(v(3'd6, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 1));
    run_instr("ill_trap", 7'h7F, 3'd0, 7'h00, 1'b0, 0);
    check("halt instret", instret, exp_instret);
    rst_n = 1'b0;
    #1;
    check("halt reset outputs", 64'(obs), 64'd0);
    exp_instret = 64'd0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`else
    // Illegal encodings retire as NOPs with a one-cycle illegal pulse.
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 1, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 1));
    run_instr("ill_7f", 7'h7F, 3'd0, 7'h00, 1'b0, 1);
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 1, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 1));
    run_instr("ill_f7", 7'h33, 3'd0, 7'h01, 1'b0, 1);
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 1, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 1));
    run_instr("ill_addi", 7'h13, 3'd1, 7'h00, 1'b0, 1);
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 1, 2'd0, 0, 0, 0, 0, 3'd2, 2'd0, 1));
    run_instr("ill_blt", 7'h63, 3'd4, 7'h00, 1'b0, 1);
`endif

    // Reset asserted in EXEC aborts the instruction immediately.
    exp_q.push_back(f_vec);
    exp_q.push_back(v(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    run_instr("add_rst", 7'h33, 3'd0, 7'h20, 1'b0, 0);
    check("add_rst exec", 64'(obs), 64'(v(3'd3, 0, 0, 2'd0, 0, 0, 1, 0, 3'd0, 2'd0, 0)));
    rst_n = 1'b0;
    #1;
    check("midexec reset outputs", 64'(obs), 64'd0);
    check("midexec reset instret", instret, 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart fetch", 64'(obs), 64'(f_vec));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
